// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared constants, route-FIFO entry type and AW FSM state
//                encoding for the AXI write-address router.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    // Default configuration of the router
    localparam int C_NUM_M       = 3;
    localparam int C_NUM_S       = 6;
    localparam int C_ID_W        = 4;
    localparam int C_IDS_W       = 8;
    localparam int C_ADDR_W      = 32;
    localparam int C_LEN_W       = 4;
    localparam int C_SIZE_W      = 3;
    localparam int C_ROUTE_DEPTH = 4;

    // Index widths at the default configuration
    localparam int C_MI_W = $clog2(C_NUM_M);
    localparam int C_SI_W = $clog2(C_NUM_S + 1);

    // One route-FIFO entry: which master sent the burst, which slave took it
    typedef struct packed {
        logic [C_MI_W-1:0] mst;
        logic [C_SI_W-1:0] slv;
    } route_t;

    // AW channel controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2
    } aw_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_route_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_route_fifo
//  Description : Synchronous FIFO holding the master->slave order of accepted
//                write bursts. Push when full and pop when empty are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_route_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    always_comb begin
        empty     = (r_wr_ptr == r_rd_ptr);
        full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                    (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        dout      = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    end

    // Storage and pointer update; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
                r_wr_ptr                     <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_aw_router.sv
`default_nettype none
// ============================================================================
//  Module      : axi_aw_router
//  Description : AXI write-address interconnect stage. Round-robin arbitration
//                over NUM_M masters, one registered address slice, address
//                decode to NUM_S slaves with an internal DECERR slave, master
//                index ID extension and a write-route FIFO for the W/B logic.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_aw_router
    import axi_pkg::*;
#(
    parameter int NUM_M       = C_NUM_M,
    parameter int NUM_S       = C_NUM_S,
    parameter int ID_W        = C_ID_W,
    parameter int IDS_W       = C_IDS_W,
    parameter int ADDR_W      = C_ADDR_W,
    parameter int LEN_W       = C_LEN_W,
    parameter int SIZE_W      = C_SIZE_W,
    parameter int ROUTE_DEPTH = C_ROUTE_DEPTH,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0005_0000, 32'h0004_0000,
                                                   32'h0003_0000, 32'h0002_0000,
                                                   32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {NUM_S{32'hFFFF_0000}},
    localparam int MI_W = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int SI_W = $clog2(NUM_S + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M*ID_W-1:0]   awid_m,
    input  logic [NUM_M*ADDR_W-1:0] awaddr_m,
    input  logic [NUM_M*LEN_W-1:0]  awlen_m,
    input  logic [NUM_M*SIZE_W-1:0] awsize_m,
    input  logic [NUM_M*2-1:0]      awburst_m,
    input  logic [NUM_M-1:0]        awvalid_m,
    output logic [NUM_M-1:0]        awready_m,
    output logic [IDS_W-1:0]        awid_s,
    output logic [ADDR_W-1:0]       awaddr_s,
    output logic [LEN_W-1:0]        awlen_s,
    output logic [SIZE_W-1:0]       awsize_s,
    output logic [1:0]              awburst_s,
    output logic [NUM_S-1:0]        awvalid_s,
    input  logic [NUM_S-1:0]        awready_s,
    output logic                    route_valid,
    output logic [MI_W-1:0]         route_mst,
    output logic [SI_W-1:0]         route_slv,
    input  logic                    route_pop,
    output logic                    decerr_valid,
    output logic [IDS_W-1:0]        decerr_id
);

    aw_state_t         r_state;
    aw_state_t         w_state_nxt;
    logic              r_up;
    logic [MI_W-1:0]   r_rr_ptr;

    logic [NUM_M-1:0]  w_req_rot;
    logic [MI_W-1:0]   w_off;
    logic [MI_W:0]     w_gnt_sum;
    logic              w_gnt_valid;
    logic [MI_W-1:0]   w_gnt_idx;
    logic              w_hs;
    logic              w_slv_ready;

    logic [ID_W-1:0]   w_sel_id;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;
    logic [SIZE_W-1:0] w_sel_size;
    logic [1:0]        w_sel_burst;
    logic [SI_W-1:0]   w_dec_slv;
    logic [IDS_W-1:0]  w_ext_id;

    logic [IDS_W-1:0]  r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [SIZE_W-1:0] r_size;
    logic [1:0]        r_burst;
    logic [SI_W-1:0]   r_slv;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [MI_W+SI_W-1:0] w_fifo_head;

    // Round-robin pick: rotate requests so the RR pointer sits at bit 0, take the lowest set bit
    always_comb begin
        w_req_rot   = NUM_M'({awvalid_m, awvalid_m} >> r_rr_ptr);
        w_gnt_valid = 1'b0;
        w_off       = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_gnt_valid = 1'b1;
                w_off       = MI_W'(i);
            end
        end
        w_gnt_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_gnt_sum >= (MI_W+1)'(NUM_M)) begin
            w_gnt_sum = w_gnt_sum - (MI_W+1)'(NUM_M);
        end
        w_gnt_idx = w_gnt_sum[MI_W-1:0];
    end

    // Field mux for the granted master, lowest-index address decode, ID extension
    always_comb begin
        w_sel_id    = '0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_size  = '0;
        w_sel_burst = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (w_gnt_idx == MI_W'(m)) begin
                w_sel_id    = awid_m[m*ID_W +: ID_W];
                w_sel_addr  = awaddr_m[m*ADDR_W +: ADDR_W];
                w_sel_len   = awlen_m[m*LEN_W +: LEN_W];
                w_sel_size  = awsize_m[m*SIZE_W +: SIZE_W];
                w_sel_burst = awburst_m[m*2 +: 2];
            end
        end
        w_dec_slv = SI_W'(NUM_S);
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((w_sel_addr & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W]) begin
                w_dec_slv = SI_W'(s);
            end
        end
        w_ext_id                 = '0;
        w_ext_id[ID_W-1:0]       = w_sel_id;
        w_ext_id[ID_W +: MI_W]   = w_gnt_idx;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and slave-side outputs; a full route FIFO blocks the grant
    always_comb begin
        w_state_nxt  = r_state;
        w_hs         = 1'b0;
        w_slv_ready  = 1'b0;
        awvalid_s    = '0;
        decerr_valid = 1'b0;
        decerr_id    = '0;
        case (r_state)
            ST_IDLE: begin
                w_hs = r_up && w_gnt_valid && !w_fifo_full;
                if (w_hs) begin
                    w_state_nxt = (w_dec_slv == SI_W'(NUM_S)) ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                for (int s = 0; s < NUM_S; s++) begin
                    awvalid_s[s] = (r_slv == SI_W'(s));
                    if (awvalid_s[s] && awready_s[s]) begin
                        w_slv_ready = 1'b1;
                    end
                end
                if (w_slv_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                decerr_valid = 1'b1;
                decerr_id    = r_id;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ready goes only to the granted master, and only when the handshake can complete
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            awready_m[m] = w_hs && (w_gnt_idx == MI_W'(m));
        end
    end

    // Address slice, RR pointer and post-reset enable (keeps awready_m low while in reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up     <= 1'b0;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_slv    <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_hs) begin
                r_rr_ptr <= (w_gnt_idx == MI_W'(NUM_M - 1)) ? '0 : w_gnt_idx + 1'b1;
                r_id     <= w_ext_id;
                r_addr   <= w_sel_addr;
                r_len    <= w_sel_len;
                r_size   <= w_sel_size;
                r_burst  <= w_sel_burst;
                r_slv    <= w_dec_slv;
            end
        end
    end

    assign awid_s    = r_id;
    assign awaddr_s  = r_addr;
    assign awlen_s   = r_len;
    assign awsize_s  = r_size;
    assign awburst_s = r_burst;

    axi_route_fifo #(
        .WIDTH (MI_W + SI_W),
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_hs),
        .din   ({w_gnt_idx, w_dec_slv}),
        .pop   (route_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign route_valid = !w_fifo_empty;
    assign route_mst   = w_fifo_head[SI_W +: MI_W];
    assign route_slv   = w_fifo_head[SI_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_aw_router
//  Description : Self-checking directed bench for axi_aw_router with a slave
//                side scoreboard and a route-FIFO scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_aw_router;
    import axi_pkg::*;

    localparam int NM = 3;
    localparam int NS = 6;
    localparam logic [NS*32-1:0] BASE = {32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
                                         32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {NS{32'hFFFF_0000}};

    logic          clk;
    logic          rst;
    logic [NM*4-1:0]  awid_m;
    logic [NM*32-1:0] awaddr_m;
    logic [NM*4-1:0]  awlen_m;
    logic [NM*3-1:0]  awsize_m;
    logic [NM*2-1:0]  awburst_m;
    logic [NM-1:0]    awvalid_m;
    logic [NM-1:0]    awready_m;
    logic [7:0]       awid_s;
    logic [31:0]      awaddr_s;
    logic [3:0]       awlen_s;
    logic [2:0]       awsize_s;
    logic [1:0]       awburst_s;
    logic [NS-1:0]    awvalid_s;
    logic [NS-1:0]    awready_s;
    logic             route_valid;
    logic [1:0]       route_mst;
    logic [2:0]       route_slv;
    logic             route_pop;
    logic             decerr_valid;
    logic [7:0]       decerr_id;

    typedef struct packed {
        logic [2:0]  slv;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } exp_t;

    exp_t   exp_q[$];
    route_t rt_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    axi_aw_router #(
        .NUM_M(NM), .NUM_S(NS), .ID_W(4), .IDS_W(8), .ADDR_W(32), .LEN_W(4),
        .SIZE_W(3), .ROUTE_DEPTH(4), .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awburst_m(awburst_m), .awvalid_m(awvalid_m), .awready_m(awready_m),
        .awid_s(awid_s), .awaddr_s(awaddr_s), .awlen_s(awlen_s), .awsize_s(awsize_s),
        .awburst_s(awburst_s), .awvalid_s(awvalid_s), .awready_s(awready_s),
        .route_valid(route_valid), .route_mst(route_mst), .route_slv(route_slv),
        .route_pop(route_pop), .decerr_valid(decerr_valid), .decerr_id(decerr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++) begin
            if ((a & MASK[s*32 +: 32]) == BASE[s*32 +: 32]) return 3'(s);
        end
        return 3'(NS);
    endfunction

    task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] addr, input logic v);
        awid_m[m*4 +: 4]    = id;
        awaddr_m[m*32 +: 32] = addr;
        awlen_m[m*4 +: 4]   = 4'(m + 5);
        awsize_m[m*3 +: 3]  = 3'(m);
        awburst_m[m*2 +: 2] = 2'b01;
        awvalid_m[m]        = v;
    endtask

    task automatic expect_burst(input int m, input logic [3:0] id, input logic [31:0] addr);
        exp_t   e;
        route_t r;
        e.slv   = decode(addr);
        e.id    = {2'b00, 2'(m), id};
        e.addr  = addr;
        e.len   = 4'(m + 5);
        e.size  = 3'(m);
        e.burst = 2'b01;
        exp_q.push_back(e);
        r.mst = 2'(m);
        r.slv = e.slv;
        rt_q.push_back(r);
    endtask

    // Waits (bounded) for master m's handshake, then steps past the accepting edge
    task automatic wait_hs(input int m, output int cyc);
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awvalid_m[m] && awready_m[m]) begin
                cyc = i;
                break;
            end
        end
        chk("hs_seen", 64'(cyc >= 0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_route();
        route_t r;
        chk("route_valid", 64'(route_valid), 64'd1);
        chk("route_sb_nonempty", 64'(rt_q.size() != 0), 64'd1);
        if (rt_q.size() != 0) begin
            r = rt_q.pop_front();
            chk("route_head", 64'({route_mst, route_slv}), 64'(r));
        end
        route_pop = 1'b1;
        @(posedge clk);
        #1;
        route_pop = 1'b0;
    endtask

    // Slave-side scoreboard: every AW handshake or DECERR absorption pops one expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                if (awvalid_s[s] && awready_s[s]) begin
                    chk("aw_sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("aw_beat", 64'({3'(s), awid_s, awaddr_s, awlen_s, awsize_s, awburst_s}), 64'(e));
                    end
                end
            end
            if (decerr_valid) begin
                chk("err_sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("decerr_beat", 64'({3'(NS), decerr_id}), 64'({e.slv, e.id}));
                end
            end
        end
    end

    initial begin
        int c;
        int k;
        int order [4];
        int slv_of [3];
        logic [NM-1:0] hs;
        logic ok;

        rst = 1'b1; route_pop = 1'b0; awready_s = '1;
        awid_m = '0; awaddr_m = '0; awlen_m = '0; awsize_m = '0; awburst_m = '0; awvalid_m = '1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with all masters requesting
        chk("rst_awready_m", 64'(awready_m), 64'd0);
        chk("rst_awvalid_s", 64'(awvalid_s), 64'd0);
        chk("rst_route_valid", 64'(route_valid), 64'd0);
        chk("rst_decerr", 64'(decerr_valid), 64'd0);
        chk("rst_data", 64'({awid_s, awaddr_s, route_mst, route_slv}), 64'd0);
        awvalid_m = '0;
        rst = 1'b0;

        // 1: reset in the middle of an ISSUE to slave 2
        awready_s = '0;
        set_m(0, 4'd1, 32'h0002_0000, 1'b1);
        wait_hs(0, c);
        awvalid_m[0] = 1'b0;
        chk("t1_issue", 64'(awvalid_s), 64'b000100);
        #2 rst = 1'b1;
        #1;
        chk("t1_awvalid_s", 64'(awvalid_s), 64'd0);
        chk("t1_awready_m", 64'(awready_m), 64'd0);
        chk("t1_flags", 64'({route_valid, decerr_valid}), 64'd0);
        chk("t1_data", 64'({awid_s, awaddr_s, route_slv}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        awready_s = '1;
        @(negedge clk);
        chk("t1_fifo_empty", 64'(route_valid), 64'd0);
        @(posedge clk);
        #1;

        // 2: three masters requesting continuously, round-robin M0,M1,M2,M0
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        slv_of[0] = 0; slv_of[1] = 1; slv_of[2] = 3;
        expect_burst(0, 4'd1, 32'h0000_0100);
        expect_burst(1, 4'd2, 32'h0001_0040);
        expect_burst(2, 4'd3, 32'h0003_0000);
        expect_burst(0, 4'd1, 32'h0000_0100);
        set_m(0, 4'd1, 32'h0000_0100, 1'b1);
        set_m(1, 4'd2, 32'h0001_0040, 1'b1);
        set_m(2, 4'd3, 32'h0003_0000, 1'b1);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            hs = awvalid_m & awready_m;
            if (hs != '0) begin
                chk("t2_grant", 64'(hs), 64'(3'b001 << order[k]));
                @(posedge clk);
                #1;
                chk("t2_latency", 64'(awvalid_s), 64'(6'b000001 << slv_of[order[k]]));
                k++;
            end
        end
        chk("t2_grant_count", 64'(k), 64'd4);
        awvalid_m = '0;
        repeat (4) pop_route();
        chk("t2_drained", 64'(route_valid), 64'd0);

        // 3: slave 1 holds awready low for 5 cycles
        awready_s = 6'b111101;
        set_m(1, 4'd4, 32'h0001_0040, 1'b1);
        expect_burst(1, 4'd4, 32'h0001_0040);
        wait_hs(1, c);
        awvalid_m[1] = 1'b0;
        set_m(0, 4'd5, 32'h0000_0200, 1'b1);
        expect_burst(0, 4'd5, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            chk("t3_awvalid_s", 64'(awvalid_s), 64'b000010);
            chk("t3_fields", 64'({awid_s, awaddr_s, awlen_s}), 64'({8'h14, 32'h0001_0040, 4'd6}));
            chk("t3_awready_m", 64'(awready_m), 64'd0);
            @(posedge clk);
            #1;
        end
        awready_s = '1;
        wait_hs(0, c);
        awvalid_m[0] = 1'b0;
        repeat (2) pop_route();

        // 4: unmapped address from M2 is absorbed as DECERR
        set_m(2, 4'd3, 32'hFFFF_0000, 1'b1);
        expect_burst(2, 4'd3, 32'hFFFF_0000);
        wait_hs(2, c);
        awvalid_m[2] = 1'b0;
        chk("t4_decerr", 64'(decerr_valid), 64'd1);
        chk("t4_decerr_id", 64'(decerr_id), 64'h23);
        chk("t4_no_awvalid", 64'(awvalid_s), 64'd0);
        chk("t4_route_slv", 64'(route_slv), 64'(NS));
        @(posedge clk);
        #1;
        chk("t4_pulse_end", 64'(decerr_valid), 64'd0);
        pop_route();

        // 5: four bursts fill the route FIFO, fifth stalls until one pop
        for (int i = 0; i < 4; i++) begin
            set_m(i % 3, 4'(i), 32'(i) << 16, 1'b1);
            expect_burst(i % 3, 4'(i), 32'(i) << 16);
            wait_hs(i % 3, c);
            awvalid_m[i % 3] = 1'b0;
        end
        set_m(1, 4'd7, 32'h0004_0000, 1'b1);
        expect_burst(1, 4'd7, 32'h0004_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_stall", 64'(awready_m), 64'd0);
        end
        @(posedge clk);
        #1;
        pop_route();
        wait_hs(1, c);
        chk("t5_resume_next_idle", 64'(c == 0), 64'd1);
        awvalid_m[1] = 1'b0;
        repeat (4) pop_route();
        chk("t5_drained", 64'(route_valid), 64'd0);

        // 6: three entries, then push and pop in the same cycle
        set_m(2, 4'd8, 32'h0005_0000, 1'b1);
        expect_burst(2, 4'd8, 32'h0005_0000);
        wait_hs(2, c);
        awvalid_m[2] = 1'b0;
        set_m(0, 4'd9, 32'h0002_0010, 1'b1);
        expect_burst(0, 4'd9, 32'h0002_0010);
        wait_hs(0, c);
        awvalid_m[0] = 1'b0;
        set_m(1, 4'd10, 32'h0000_0020, 1'b1);
        expect_burst(1, 4'd10, 32'h0000_0020);
        wait_hs(1, c);
        awvalid_m[1] = 1'b0;
        set_m(2, 4'd11, 32'h0003_0030, 1'b1);
        expect_burst(2, 4'd11, 32'h0003_0030);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready_m[2]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_hs_seen", 64'(ok), 64'd1);
        if (ok) begin
            chk("t6_head_before", 64'({route_mst, route_slv}), 64'(rt_q[0]));
            void'(rt_q.pop_front());
            route_pop = 1'b1;
        end
        @(posedge clk);
        #1;
        route_pop = 1'b0;
        awvalid_m[2] = 1'b0;
        repeat (3) pop_route();
        chk("t6_count_three", 64'(route_valid), 64'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("aw_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("route_sb_empty", 64'(rt_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
